// File: rtl/servo_position_sequencer_if.sv
// Command handshake between the key/command logic and the position sequencer.
// Producer holds cmd_valid with stable payload until cmd_ready is seen high.
interface servo_position_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_pos;
   logic [7:0] cmd_dwell;

   modport master (output cmd_valid, output cmd_pos, output cmd_dwell, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_pos, input cmd_dwell, output cmd_ready);
endinterface

// File: rtl/servo_position_sequencer.sv
// Queued servo target sequencer: slews duty_cycle by <= STEP per PWM frame, then dwells.
// Position updates one cycle after frame_tick; cmd_ready low while the command FIFO is full.
module servo_position_sequencer #(
   parameter int FRAME_CLKS = 1000000,
   parameter int STEP       = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int INIT_POS   = 128
)(
   input  logic                          Main_clock,
   input  logic                          reset,
   input  logic                          enable,
   servo_position_sequencer_if.slave     cmd,
   output logic [7:0]                    duty_cycle,
   output logic                          frame_tick,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int                CNT_W   = $clog2(FRAME_CLKS);
   localparam int                PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  L_LAST  = CNT_W'(FRAME_CLKS - 1);
   localparam logic [PTR_W:0]    L_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [8:0]        L_STEP9 = 9'(STEP);
   localparam logic [7:0]        L_STEP8 = 8'(STEP);
   localparam logic [7:0]        L_INIT  = 8'(INIT_POS);

   typedef enum logic [1:0] {S_IDLE, S_RAMP, S_DWELL} state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_frame_cnt;
   logic               r_tick;
   logic [15:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]     r_count;
   logic [7:0]         r_duty, r_target, r_dwell;
   logic [7:0]         w_duty_nxt, w_target_nxt, w_dwell_nxt;
   logic               w_push, w_pop;
   logic [15:0]        w_head;
   logic signed [8:0]  w_diff;
   logic [8:0]         w_mag;

   assign cmd.cmd_ready = (r_count < L_DEPTH) && !reset;
   assign w_push        = cmd.cmd_valid && cmd.cmd_ready;
   assign w_head        = r_mem[r_rd_ptr];
   assign w_diff        = $signed({1'b0, r_target}) - $signed({1'b0, r_duty});
   assign w_mag         = w_diff[8] ? $unsigned(-w_diff) : $unsigned(w_diff);

   assign duty_cycle = r_duty;
   assign frame_tick = r_tick;
   assign fifo_count = r_count;
   assign busy       = (r_state != S_IDLE) || (r_count != '0);

   // Frame timebase; disabling restarts a full frame on re-enable.
   always_ff @(posedge Main_clock or posedge reset) begin
      if (reset) begin
         r_frame_cnt <= '0;
         r_tick      <= 1'b0;
      end else if (!enable) begin
         r_frame_cnt <= '0;
         r_tick      <= 1'b0;
      end else if (r_frame_cnt == L_LAST) begin
         r_frame_cnt <= '0;
         r_tick      <= 1'b1;
      end else begin
         r_frame_cnt <= r_frame_cnt + 1'b1;
         r_tick      <= 1'b0;
      end
   end

   always_ff @(posedge Main_clock) begin
      if (w_push) r_mem[r_wr_ptr] <= {cmd.cmd_pos, cmd.cmd_dwell};
   end

   always_ff @(posedge Main_clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge Main_clock or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_duty   <= L_INIT;
         r_target <= L_INIT;
         r_dwell  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_duty   <= w_duty_nxt;
         r_target <= w_target_nxt;
         r_dwell  <= w_dwell_nxt;
      end
   end

   // Loading ignores frame_tick, so the arrival tick and first dwell tick are always distinct.
   always_comb begin
      w_state_nxt  = r_state;
      w_duty_nxt   = r_duty;
      w_target_nxt = r_target;
      w_dwell_nxt  = r_dwell;
      w_pop        = 1'b0;
      if (enable) begin
         case (r_state)
            S_IDLE: begin
               if (r_count != '0) begin
                  w_pop        = 1'b1;
                  w_target_nxt = w_head[15:8];
                  w_dwell_nxt  = w_head[7:0];
                  w_state_nxt  = (w_head[15:8] == r_duty) ? S_DWELL : S_RAMP;
               end
            end
            S_RAMP: begin
               if (r_tick) begin
                  if (w_mag <= L_STEP9) begin
                     w_duty_nxt  = r_target;
                     w_state_nxt = S_DWELL;
                  end else if (w_diff[8]) begin
                     w_duty_nxt = r_duty - L_STEP8;
                  end else begin
                     w_duty_nxt = r_duty + L_STEP8;
                  end
               end
            end
            S_DWELL: begin
               if (r_dwell == '0) begin
                  w_state_nxt = S_IDLE;
               end else if (r_tick) begin
                  w_dwell_nxt = r_dwell - 8'd1;
                  if (r_dwell == 8'd1) w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/servo_position_sequencer.md
Name: servo_position_sequencer

Overview:
Command-driven position sequencer that generates the 8-bit duty_cycle input of the servo PWM controller. Target positions with dwell times are queued in a small FIFO. The block slews duty_cycle toward each target by at most STEP per PWM frame, holds for the dwell, then takes the next command. It sits between the key/command logic and the servo controller, and updates the position only on frame boundaries so the PWM never sees a mid-period change.

Parameters:
FRAME_CLKS, 1000000, Main_clock cycles per PWM frame (20 ms at 50 MHz); must be >= 2
STEP, 1, maximum duty_cycle change per frame; range 1..255
FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16
INIT_POS, 128, duty_cycle value after reset (servo centre)

Ports:
Main_clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high reset
enable  in  1  run enable; low freezes the sequencer
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_pos  in  8  target duty_cycle
cmd_dwell  in  8  frames to hold at the target after arrival
duty_cycle  out  8  position to the servo controller, registered
frame_tick  out  1  one-cycle pulse at each frame end
busy  out  1  command in progress or queued
fifo_count  out  log2(FIFO_DEPTH)+1  entries queued

Behaviour:
- Reset (async, active-high) values:
  - duty_cycle=INIT_POS, frame_tick=0, busy=0, fifo_count=0.
  - FSM=IDLE; frame counter and dwell counter at 0.
  - cmd_ready is forced to 0 while reset is high.
  - Reset mid-ramp or mid-dwell discards all queued and active commands.
- Frame counter:
  - Counts 0..FRAME_CLKS-1 while enable=1.
  - frame_tick=1 for exactly the cycle after the counter holds FRAME_CLKS-1, then the counter wraps to 0.
  - enable=0: counter cleared to 0, no ticks, FSM and duty_cycle held. FIFO still accepts pushes.
- FIFO:
  - cmd_ready = (fifo_count < FIFO_DEPTH) && !reset.
  - Push on cmd_valid && cmd_ready, storing {cmd_pos, cmd_dwell}.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - A full FIFO drops nothing because the producer must hold cmd_valid.
  - Order is FIFO; pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE:
    - If enable && fifo_count != 0: pop, load target=cmd_pos and dwell_cnt=cmd_dwell.
    - Next state is DWELL if target==duty_cycle, else RAMP.
    - Loading takes 1 cycle and does not wait for a frame_tick.
  - RAMP, on each frame_tick:
    - diff = target - duty_cycle, computed in 9-bit signed.
    - If |diff| <= STEP: duty_cycle <= target and go to DWELL.
    - Otherwise duty_cycle moves by +/-STEP toward target.
    - No wrap is possible; the intermediate result never leaves 0..255.
  - DWELL:
    - If dwell_cnt==0, go to IDLE on the next cycle, with no tick needed.
    - Otherwise dwell_cnt decrements on each frame_tick; go to IDLE when it decrements to 0.
- Output timing:
  - duty_cycle changes only in the cycle after a frame_tick.
  - The arrival update and the first dwell count use separate ticks.
- busy = (state != IDLE) || (fifo_count != 0).
- Simultaneous events:
  - A push in the same cycle as an IDLE pop of the last entry leaves fifo_count=1.
  - A frame_tick in the cycle a command loads is not applied to that command.

Test Plan:
- Reset release: FRAME_CLKS=10, INIT_POS=128 -> duty_cycle=128, busy=0, cmd_ready=1; frame_tick every 10 cycles with no other change.
- Up-ramp: STEP=4, cmd_pos=140, dwell=2 -> duty_cycle goes 132, 136, 140 on successive ticks, holds 2 more ticks, then busy=0.
- Down-ramp with remainder: start 128, STEP=5, cmd_pos=120 -> 123, then 120 (clamped to target), then DWELL.
- FIFO full and ordering: DEPTH=4, push 5 commands back-to-back while enable=0 -> cmd_ready drops after 4, fifo_count=4; raise enable -> targets execute in push order and the 5th is accepted after the first pop.
- Zero cases: cmd_pos equal to the current position with dwell=0 -> popped and back to IDLE within 3 cycles, duty_cycle unchanged; extremes cmd_pos=0 then 255 with STEP=255 -> single-tick jumps, no wrap.
- Freeze and abort: drop enable mid-RAMP -> no ticks and duty_cycle held; re-enable -> resumes after a full FRAME_CLKS; assert reset mid-DWELL -> duty_cycle=128 and fifo_count=0 immediately, asynchronously.
